modport_ram: RTL and testbench
==============================

MODPORT_RAM -- requirements
Module: modport_ram

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 12, address width in bits.
REQ-003 SHALL have parameter DEPTH, default 4096 (2**ADDR_WIDTH), number of words.
REQ-004 SHALL have port clk, input, 1, single clock; all sequential logic on rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port data_in, input, DATA_WIDTH, write data.
REQ-007 SHALL have port write_address, input, ADDR_WIDTH, write word address.
REQ-008 SHALL have port write_enable, input, 1, write strobe.
REQ-009 SHALL have port read_address, input, ADDR_WIDTH, read word address.
REQ-010 SHALL have port read_enable, input, 1, read strobe.
REQ-011 SHALL have port data_out, output, DATA_WIDTH, registered read data.
REQ-012 SHALL use one clock, with reset synchronous and active-high; no other clock or asynchronous input.

Function
REQ-013 SHALL contain DEPTH words of DATA_WIDTH bits, with independent read and write ports usable in the same cycle.
REQ-014 SHALL write: when write_enable=1 and reset=0 at a rising clk, mem[write_address] <= data_in.
REQ-015 SHALL leave memory unchanged when write_enable=0.
REQ-016 SHALL read: when read_enable=1 and reset=0 at a rising clk, data_out <= mem[read_address]; latency 1 cycle, valid after that edge.
REQ-017 SHALL hold data_out at its previous value when read_enable=0.
REQ-018 SHALL be read-first on a same-address collision: if read and write hit the same address in one cycle, data_out returns the old word and the new word is stored.
REQ-019 SHALL make a write visible to any read issued on a later cycle.
REQ-020 SHALL cover the full address range 0..DEPTH-1, with no wrap-around or out-of-range condition at the default parameters.
REQ-021 SHALL make a word never written since power-up read as X in simulation; the bench SHALL NOT check it.

Reset
REQ-022 SHALL clear data_out to 0 on the first rising clk where reset=1.
REQ-023 SHALL hold data_out at 0 while reset=1.
REQ-024 SHALL ignore write_enable and read_enable while reset=1; memory contents SHALL NOT be modified or cleared by reset.
REQ-025 SHALL resume normal operation on the first rising clk with reset=0; memory written before reset SHALL remain readable after reset.

Verification
REQ-026 Write/read-back: write 64'hDEAD_BEEF_CAFE_0001 to address 12'h005; next cycle read 12'h005 -> data_out = 64'hDEAD_BEEF_CAFE_0001 one cycle after read_enable.
REQ-027 Boundary addresses: write 64'h1 to 12'h000 and 64'hFFFF_FFFF_FFFF_FFFF to 12'hFFF; read both -> the respective values, with no aliasing.
REQ-028 Collision: 12'h010 holds 64'hA; in one cycle write 64'hB to 12'h010 and read 12'h010 -> data_out = 64'hA; a read on the next cycle -> 64'hB.
REQ-029 Hold: after a read returns 64'h1234, drop read_enable for 3 cycles while changing read_address -> data_out stays 64'h1234.
REQ-030 Reset mid-operation: store 64'h55 at 12'h020, assert reset 2 cycles with write_enable=1 of 64'h99 to 12'h020 -> data_out = 0 during reset; after release, a read of 12'h020 -> 64'h55.
REQ-031 Concurrent ports: 16 back-to-back cycles writing address i with data i while reading address i-1 -> each read returns i-1.

Source files
------------

// File: rtl/modport_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port,
// read-first on same-address collision, reset clears only the read register.
module modport_ram #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DEPTH      = 4096
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ADDR_WIDTH-1:0] write_address,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] read_address,
  input  logic                  read_enable,
  output logic [DATA_WIDTH-1:0] data_out
);

  logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];

  // Write port; reset gates the strobe but never clears the array.
  always_ff @(posedge clk) begin
    if (!reset && write_enable) begin
      r_mem[write_address] <= data_in;
    end
  end

  // Read port samples the pre-edge array contents, giving read-first behaviour.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out <= '0;
    end else if (read_enable) begin
      data_out <= r_mem[read_address];
    end
  end

endmodule

// File: tb/tb_modport_ram.sv
// Directed self-checking bench for modport_ram: reset, read-back, boundaries,
// collision, hold, reset mid-operation and back-to-back concurrent access.
module tb_modport_ram;

  localparam int unsigned DW = 64;
  localparam int unsigned AW = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] data_in;
  logic [AW-1:0] write_address;
  logic          write_enable;
  logic [AW-1:0] read_address;
  logic          read_enable;
  logic [DW-1:0] data_out;

  int checks = 0;
  int errors = 0;

  modport_ram #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .DEPTH     (4096)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .data_in      (data_in),
    .write_address(write_address),
    .write_enable (write_enable),
    .read_address (read_address),
    .read_enable  (read_enable),
    .data_out     (data_out)
  );

  always #5 clk = ~clk;

  // Advance one rising edge, then settle before sampling/driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] exp);
    checks++;
    assert (data_out === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, data_out, exp);
    end
  endtask

  initial begin
    reset         = 1'b1;
    data_in       = '0;
    write_address = '0;
    write_enable  = 1'b0;
    read_address  = '0;
    read_enable   = 1'b0;
    step();
    step();
    chk("reset_state", 64'h0);

    // Write/read-back
    reset         = 1'b0;
    write_enable  = 1'b1;
    write_address = 12'h005;
    data_in       = 64'hDEAD_BEEF_CAFE_0001;
    step();
    write_enable  = 1'b0;
    read_enable   = 1'b1;
    read_address  = 12'h005;
    step();
    chk("readback_005", 64'hDEAD_BEEF_CAFE_0001);
    read_enable   = 1'b0;

    // Boundary addresses
    write_enable  = 1'b1;
    write_address = 12'h000;
    data_in       = 64'h1;
    step();
    write_address = 12'hFFF;
    data_in       = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    write_enable  = 1'b0;
    read_enable   = 1'b1;
    read_address  = 12'h000;
    step();
    chk("boundary_000", 64'h1);
    read_address  = 12'hFFF;
    step();
    chk("boundary_fff", 64'hFFFF_FFFF_FFFF_FFFF);
    read_enable   = 1'b0;

    // Same-address collision: old word returned, new word stored
    write_enable  = 1'b1;
    write_address = 12'h010;
    data_in       = 64'hA;
    step();
    data_in       = 64'hB;
    read_enable   = 1'b1;
    read_address  = 12'h010;
    step();
    chk("collision_old", 64'hA);
    write_enable  = 1'b0;
    step();
    chk("collision_new", 64'hB);
    read_enable   = 1'b0;

    // Hold with read_enable low while read_address moves
    write_enable  = 1'b1;
    write_address = 12'h030;
    data_in       = 64'h1234;
    step();
    write_enable  = 1'b0;
    read_enable   = 1'b1;
    read_address  = 12'h030;
    step();
    chk("hold_load", 64'h1234);
    read_enable   = 1'b0;
    for (int k = 0; k < 3; k++) begin
      read_address = 12'(12'h005 + k);
      step();
      chk("hold", 64'h1234);
    end

    // Reset mid-operation: strobes ignored, memory retained
    write_enable  = 1'b1;
    write_address = 12'h020;
    data_in       = 64'h55;
    step();
    reset         = 1'b1;
    data_in       = 64'h99;
    read_enable   = 1'b1;
    read_address  = 12'h005;
    step();
    chk("reset_mid_1", 64'h0);
    step();
    chk("reset_mid_2", 64'h0);
    reset         = 1'b0;
    write_enable  = 1'b0;
    read_address  = 12'h020;
    step();
    chk("after_reset_020", 64'h55);

    // Concurrent ports: write i, read i-1 (i=0 reads 12'hFFF)
    for (int i = 0; i < 16; i++) begin
      write_enable  = 1'b1;
      write_address = 12'(i);
      data_in       = 64'(i);
      read_enable   = 1'b1;
      read_address  = 12'(i - 1);
      step();
      chk($sformatf("concurrent_%0d", i),
          (i == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'(i - 1));
    end
    write_enable  = 1'b0;
    read_address  = 12'h00F;
    step();
    chk("concurrent_last", 64'hF);
    read_enable   = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
